// File: rtl/pattern_scheduler_if.sv
// Command/sync/colour bundle between a UART front end and the pattern scheduler.
// master drives RX strobe, byte and VSync; slave returns colour, mode, pending and frame count.
interface pattern_scheduler_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_VSync;
  logic [7:0] o_Byte;
  logic       o_Auto;
  logic       o_Pending;
  logic [7:0] o_Frame_Count;

  modport master (
    output i_RX_DV, i_RX_Byte, i_VSync,
    input  o_Byte, o_Auto, o_Pending, o_Frame_Count
  );

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_VSync,
    output o_Byte, o_Auto, o_Pending, o_Frame_Count
  );
endinterface

// File: rtl/pattern_scheduler.sv
// Frame-synchronous colour scheduler: UART commands wait for a VSync falling edge.
// Ports: CLK, i_Reset (sync, active high), bus (slave: RX strobe/byte, VSync in; colour/status out).
module pattern_scheduler #(
  parameter int unsigned FRAMES_PER_STEP = 60
) (
  input logic           CLK,
  input logic           i_Reset,
  pattern_scheduler_if.slave bus
);

  typedef enum logic {MANUAL, AUTO} state_t;

  localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

  state_t     state, state_nx;
  logic       vs_q;
  logic [7:0] col_q, col_nx;
  logic [7:0] cnt_q, cnt_nx;
  logic [7:0] pend_q, pend_nx;
  logic       pend_v, pend_v_nx;
  logic       boundary;
  logic       legal;
  logic       cmd_col, cmd_go, cmd_stop;
  logic [7:0] col_adv;

  assign boundary = vs_q & ~bus.i_VSync;

  always_comb begin
    legal = 1'b0;
    case (bus.i_RX_Byte)
      8'h30, 8'h31, 8'h32, 8'h33,
      8'h41, 8'h53: legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  assign cmd_col  = (pend_q[7:2] == 6'b001100);
  assign cmd_go   = (pend_q == 8'h41);
  assign cmd_stop = (pend_q == 8'h53);

  always_comb begin
    col_adv = 8'h31;
    case (col_q)
      8'h31:   col_adv = 8'h32;
      8'h32:   col_adv = 8'h33;
      default: col_adv = 8'h31;
    endcase
  end

  // New byte loads even on a boundary cycle; the boundary
  // consumes the previously registered command.
  always_comb begin
    pend_nx   = pend_q;
    pend_v_nx = pend_v;
    if (bus.i_RX_DV && legal) begin
      pend_nx   = bus.i_RX_Byte;
      pend_v_nx = 1'b1;
    end else if (boundary) begin
      pend_v_nx = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col_q;
    cnt_nx   = cnt_q;
    if (boundary) begin
      if (pend_v) begin
        unique case (1'b1)
          cmd_col: begin
            col_nx   = pend_q;
            state_nx = MANUAL;
            cnt_nx   = 8'h00;
          end
          cmd_go: begin
            col_nx   = 8'h31;
            state_nx = AUTO;
            cnt_nx   = 8'h00;
          end
          cmd_stop: begin
            state_nx = MANUAL;
            cnt_nx   = 8'h00;
          end
        endcase
      end else if (state == AUTO) begin
        if (cnt_q == LAST) begin
          col_nx = col_adv;
          cnt_nx = 8'h00;
        end else begin
          cnt_nx = cnt_q + 8'h01;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state  <= MANUAL;
      vs_q   <= 1'b1;
      col_q  <= 8'h30;
      cnt_q  <= 8'h00;
      pend_q <= 8'h00;
      pend_v <= 1'b0;
    end else begin
      state  <= state_nx;
      vs_q   <= bus.i_VSync;
      col_q  <= col_nx;
      cnt_q  <= cnt_nx;
      pend_q <= pend_nx;
      pend_v <= pend_v_nx;
    end
  end

  assign bus.o_Byte        = col_q;
  assign bus.o_Auto        = (state == AUTO);
  assign bus.o_Pending     = pend_v;
  assign bus.o_Frame_Count = cnt_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: vector table with scoreboard queue plus corner sequences.
// DUT a runs FRAMES_PER_STEP=2, DUT b runs FRAMES_PER_STEP=1 on shared stimulus.
module tb_pattern_scheduler;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] b;
    logic       vs;
    logic [7:0] eb;
    logic       ea;
    logic       ep;
    logic [7:0] ec;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] rxb = 8'h00;
  logic       vs = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  vec_t tbl[$];
  vec_t sb[$];

  pattern_scheduler_if bus_a ();
  pattern_scheduler_if bus_b ();

  assign bus_a.i_RX_DV   = dv;
  assign bus_a.i_RX_Byte = rxb;
  assign bus_a.i_VSync   = vs;
  assign bus_b.i_RX_DV   = dv;
  assign bus_b.i_RX_Byte = rxb;
  assign bus_b.i_VSync   = vs;

  pattern_scheduler #(.FRAMES_PER_STEP(2)) dut_a (
    .CLK     (clk),
    .i_Reset (rst),
    .bus     (bus_a)
  );

  pattern_scheduler #(.FRAMES_PER_STEP(1)) dut_b (
    .CLK     (clk),
    .i_Reset (rst),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(
    input logic r, input logic d, input logic [7:0] b, input logic s,
    input logic [7:0] eb, input logic ea, input logic ep, input logic [7:0] ec
  );
    vec_t t;
    t.rst = r; t.dv = d; t.b = b; t.vs = s;
    t.eb = eb; t.ea = ea; t.ep = ep; t.ec = ec;
    return t;
  endfunction

  task automatic chk(
    input string nm,
    input logic [7:0] gb, input logic ga, input logic gp, input logic [7:0] gc,
    input logic [7:0] eb, input logic ea, input logic ep, input logic [7:0] ec
  );
    n_vec++;
    if (gb !== eb || ga !== ea || gp !== ep || gc !== ec) begin
      n_bad++;
      $display("FAIL %s: got byte=%h auto=%b pend=%b cnt=%0d, want byte=%h auto=%b pend=%b cnt=%0d",
               nm, gb, ga, gp, gc, eb, ea, ep, ec);
    end
  endtask

  task automatic apply(input string nm, input vec_t t);
    vec_t e;
    @(negedge clk);
    rst = t.rst; dv = t.dv; rxb = t.b; vs = t.vs;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(nm, bus_a.o_Byte, bus_a.o_Auto, bus_a.o_Pending, bus_a.o_Frame_Count,
        e.eb, e.ea, e.ep, e.ec);
  endtask

  task automatic chk_b(input string nm, input logic [7:0] eb, input logic ea, input logic [7:0] ec);
    chk(nm, bus_b.o_Byte, bus_b.o_Auto, bus_b.o_Pending, bus_b.o_Frame_Count,
        eb, ea, 1'b0, ec);
  endtask

  initial begin
    // reset, reset priority
    tbl.push_back(v(1,0,8'h00,1, 8'h30,0,0,0));
    tbl.push_back(v(1,1,8'h31,0, 8'h30,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h30,0,0,0));
    // manual colour, held-low vsync gives one boundary
    tbl.push_back(v(0,1,8'h32,1, 8'h30,0,1,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h30,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h32,0,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h32,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h32,0,0,0));
    // last wins, illegal ignored
    tbl.push_back(v(0,1,8'h31,1, 8'h32,0,1,0));
    tbl.push_back(v(0,1,8'h33,1, 8'h32,0,1,0));
    tbl.push_back(v(0,1,8'h7A,1, 8'h32,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h33,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h33,0,0,0));
    tbl.push_back(v(0,1,8'h7A,1, 8'h33,0,0,0));
    // stop in manual, duplicate colour
    tbl.push_back(v(0,1,8'h53,1, 8'h33,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h33,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h33,0,0,0));
    tbl.push_back(v(0,1,8'h33,1, 8'h33,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h33,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h33,0,0,0));
    // auto, 7 boundaries with 2 frames per step
    tbl.push_back(v(0,1,8'h41,1, 8'h33,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,1));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,1));
    tbl.push_back(v(0,0,8'h00,0, 8'h32,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h32,1,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h32,1,0,1));
    tbl.push_back(v(0,0,8'h00,1, 8'h32,1,0,1));
    tbl.push_back(v(0,0,8'h00,0, 8'h33,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h33,1,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h33,1,0,1));
    tbl.push_back(v(0,0,8'h00,1, 8'h33,1,0,1));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,0));
    // stop on the boundary cycle: count now, exit next boundary
    tbl.push_back(v(0,1,8'h53,0, 8'h31,1,1,1));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,1,1));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,0,0,0));
    // auto restart and colour exit
    tbl.push_back(v(0,1,8'h41,1, 8'h31,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,1));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,1));
    tbl.push_back(v(0,0,8'h00,0, 8'h32,1,0,0));
    tbl.push_back(v(0,1,8'h41,1, 8'h32,1,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,1));
    tbl.push_back(v(0,1,8'h32,1, 8'h31,1,1,1));
    tbl.push_back(v(0,0,8'h00,0, 8'h32,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h32,0,0,0));
    // reset mid-auto with a pending command
    tbl.push_back(v(0,1,8'h41,1, 8'h32,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,1,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,1,0,0));
    tbl.push_back(v(0,1,8'h33,1, 8'h31,1,1,0));
    tbl.push_back(v(1,0,8'h00,1, 8'h30,0,0,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h30,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h30,0,0,0));
    // command on the boundary cycle waits for the next one
    tbl.push_back(v(0,1,8'h32,1, 8'h30,0,1,0));
    tbl.push_back(v(0,1,8'h31,0, 8'h32,0,1,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h32,0,1,0));
    tbl.push_back(v(0,0,8'h00,0, 8'h31,0,0,0));
    tbl.push_back(v(0,0,8'h00,1, 8'h31,0,0,0));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // command at cycle 10, boundary at cycle 100
    apply("c31_rst", v(1,0,8'h00,1, 8'h30,0,0,0));
    for (int c = 1; c <= 101; c++) begin
      logic [7:0] eb;
      logic       ep;
      eb = (c >= 100) ? 8'h32 : 8'h30;
      ep = (c >= 10 && c < 100);
      apply($sformatf("c31_cyc%0d", c),
            v(0, (c == 10), 8'h32, (c != 100), eb, 0, ep, 0));
    end

    // one frame per step: held-low vsync advances once
    apply("c36_rst", v(1,0,8'h00,1, 8'h30,0,0,0));
    apply("c36_go",  v(0,1,8'h41,1, 8'h30,0,1,0));
    apply("c36_b1",  v(0,0,8'h00,0, 8'h31,1,0,0));
    chk_b("c36_b1_b", 8'h31, 1, 0);
    apply("c36_hi",  v(0,0,8'h00,1, 8'h31,1,0,0));
    @(negedge clk);
    dv = 1'b0; vs = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk_b("c36_hold_b", 8'h32, 1, 0);
    chk("c36_hold_a", bus_a.o_Byte, bus_a.o_Auto, bus_a.o_Pending, bus_a.o_Frame_Count,
        8'h31, 1, 0, 1);
    apply("c36_hi2", v(0,0,8'h00,1, 8'h31,1,0,1));
    apply("c36_b3",  v(0,0,8'h00,0, 8'h32,1,0,0));
    chk_b("c36_b3_b", 8'h33, 1, 0);
    apply("c36_hi3", v(0,0,8'h00,1, 8'h32,1,0,0));
    apply("c36_b4",  v(0,0,8'h00,0, 8'h32,1,0,1));
    chk_b("c36_b4_b", 8'h31, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
